data_memory: RTL and testbench
==============================

# data_memory

CPU data memory: a 512 x 16-bit word store serving two kinds of access. Load/store use an explicit 9-bit address; push/pop use the externally maintained stack pointer. It sits in the CPU datapath behind the load/store and stack control signals. The stack pointer itself is owned and updated by the CPU, never by this block.

## Interface
- Parameter `DATA_W`, default 16: word width.
- Parameter `ADDR_W`, default 9: address width; depth is 2^ADDR_W = 512 words.
- Clocking and reset (already decided): one clock; reset is synchronous and active-low.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `data_in` input 16: write data for store and push.
- `sp` input 16: stack pointer; only `sp[8:0]` is used, upper bits ignored.
- `address` input 9: word address for load and store.
- `store` input 1: write `data_in` to `mem[address]`.
- `load` input 1: read `mem[address]` into `data_out`.
- `push` input 1: write `data_in` to `mem[sp[8:0]]`.
- `pop` input 1: read `mem[sp[8:0]]` into `data_out`.
- `data_out` output 16: registered read data.

## Operation
- Controls are level-sensitive. Each rising edge with a control high performs that access, so holding a control high repeats the access every cycle.
- **Write port** (at most one write per cycle):
  - `store` has priority: `mem[address] <= data_in`.
  - Otherwise `push`: `mem[sp[8:0]] <= data_in`.
  - If both are high, `push` is ignored.
- **Read port** (at most one read per cycle):
  - `load` has priority: `data_out <= mem[address]`.
  - Otherwise `pop`: `data_out <= mem[sp[8:0]]`.
  - If both are high, `pop` is ignored.
- Read and write ports operate independently in the same cycle.
- **Same-address read and write in one cycle:** the read returns the old contents (read-first). The new value is visible from the next cycle.
- **No read control asserted:** `data_out` holds its last value.
- **Stack addressing:**
  - No pre/post increment or decrement inside the block.
  - Push writes at exactly `sp`; pop reads at exactly `sp`.
  - `sp` values of 512 and above alias modulo 512 (truncation).
- **Reset:**
  - While `rst_n` is sampled low: `data_out <= 0` and all controls are ignored (no writes).
  - Memory array contents are not cleared and are undefined after power-up.
  - Reset asserted mid-sequence aborts that cycle's access; earlier writes persist.

## Timing
- Write latency: 1 cycle. Data is in the array after the edge where the write control is sampled high.
- Read latency: 1 cycle. `data_out` is valid after the edge where `load` or `pop` is sampled high.
- No handshake, no stall, no busy output. Every access completes in one cycle.
- All inputs are sampled only at the rising edge of `clk`. No combinational path from inputs to `data_out`.

## Structure
- Shared CPU package holds `DATA_W = 16`, `ADDR_W = 9`, and the word typedef (16-bit), reused by register file and ALU.
- One natural sub-module: `data_memory_ram`, a simple dual-port array (one write port, one read port, read-first, no reset) inferable as block RAM.
- Top level contains only:
  - write-port mux: `store` over `push`, `address` vs `sp[8:0]`;
  - read-port mux: `load` over `pop`;
  - reset gating of the write enable and of the `data_out` register.

## Test plan
- **Reset:** hold `rst_n=0` for 2 cycles with `load=1` -> `data_out=0x0000`. Then store `0x1234` with `rst_n=0` and read that address back after reset -> not `0x1234` (write suppressed).
- **Store/load:** store `0xAAAA` at `address=1`, deassert, then `load=1, address=1` -> `data_out=0xAAAA` one cycle after the load edge. With `load=0`, `data_out` holds `0xAAAA` for subsequent cycles.
- **Push/pop:** push `0xF0F0` with `sp=2`, then `pop=1, sp=2` -> `data_out=0xF0F0`. Pop at `sp=0x0202` -> reads word 2 (alias) -> `0xF0F0`.
- **Priority:**
  - `store=1, address=5, push=1, sp=6, data_in=0x1111` -> `mem[5]=0x1111`, `mem[6]` unchanged.
  - `load=1, address=5, pop=1, sp=6` -> `data_out=0x1111`.
- **Read-first:** `mem[3]=0x0001`, then in one cycle `store=1, load=1, address=3, data_in=0x0002` -> `data_out=0x0001`. Next cycle with `load=1` -> `0x0002`.
- **Boundaries:** store `0xBEEF` at address 511 and `0xCAFE` at address 0 -> load 511 returns `0xBEEF`, load 0 returns `0xCAFE`, no aliasing between them.

Source files
------------

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared CPU datapath widths and word type
// Purpose: single source of the datapath word width and data memory address
//          width, reused by the register file, ALU and data memory.
// Ports:   none (package).
package data_memory_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/data_memory_ram.sv
// rtl/data_memory_ram.sv - simple dual-port word array, read-first, no reset
// Purpose: one write port and one registered read port on a 2^ADDR_W-deep
//          array. A read and a write to the same word in one cycle return the
//          old contents. The array and the read register are never reset.
// Ports:   clk                            - clock
//          wr_en / wr_addr / wr_data      - write port
//          rd_en / rd_addr                - read port request
//          rd_data                        - registered read data, held when
//                                           rd_en is low
module data_memory_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // The array read happens before this edge's write lands, which gives
  // read-first behaviour on an address collision.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - CPU data memory with load/store and stack push/pop
// Purpose: 2^ADDR_W x DATA_W word store. Load/store use the explicit address,
//          push/pop use the CPU-owned stack pointer (low ADDR_W bits only).
//          store beats push on the write port, load beats pop on the read port.
// Ports:   clk      - clock
//          rst_n    - synchronous active-low reset; clears data_out, blocks writes
//          data_in  - write data for store and push
//          sp       - stack pointer, upper bits ignored
//          address  - word address for load and store
//          store, load, push, pop - level-sensitive access controls
//          data_out - registered read data
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_W = data_memory_pkg::DATA_W,
  parameter int ADDR_W = data_memory_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] sp,
  input  logic [ADDR_W-1:0] address,
  input  logic              store,
  input  logic              load,
  input  logic              push,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic              clear_d;
  logic              clear_q;
  logic              unused_sp;

  // Stack pointer values beyond the array depth alias by truncation.
  assign unused_sp = ^sp[DATA_W-1:ADDR_W];

  always_comb begin
    wr_en   = rst_n & (store | push);
    wr_addr = store ? address : sp[ADDR_W-1:0];
    rd_en   = rst_n & (load | pop);
    rd_addr = load ? address : sp[ADDR_W-1:0];
  end

  data_memory_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (data_in),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

  // The RAM read register has no reset, so reset is applied to data_out by a
  // flag that forces zero until the first read after reset refills it.
  always_comb begin
    clear_d = clear_q;
    if (rd_en) begin
      clear_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clear_q <= 1'b1;
    end else begin
      clear_q <= clear_d;
    end
  end

  assign data_out = clear_q ? '0 : ram_rd_data;

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - scoreboard bench for data_memory
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        store = 1'b0;
  logic        load = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] sp = '0;
  logic [8:0]  address = '0;
  logic [15:0] data_out;

  data_memory dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .sp       (sp),
    .address  (address),
    .store    (store),
    .load     (load),
    .push     (push),
    .pop      (pop),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic set_in(input logic r, input logic st, input logic ld,
                        input logic ps, input logic pp, input logic [8:0] a,
                        input logic [15:0] s, input logic [15:0] d);
    rst_n = r; store = st; load = ld; push = ps; pop = pp;
    address = a; sp = s; data_in = d;
  endtask

  // Expected data_out after the coming edge.
  task automatic expect_rd(input string nm, input logic [15:0] v);
    exp_t e;
    e.due = cyc + 1;
    e.val = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (data_out !== e.val) begin
        n_fail++;
        $display("FAIL %s: data_out=%h expected=%h", e.name, data_out, e.val);
      end
    end
  end

  initial begin
    // Reset with load held high
    set_in(0, 0, 1, 0, 0, 9'd0, 16'h0000, 16'h0000); expect_rd("reset_c1", 16'h0000); tick();
    set_in(0, 0, 1, 0, 0, 9'd0, 16'h0000, 16'h0000); expect_rd("reset_c2", 16'h0000); tick();
    // Known value, then a store attempted under reset
    set_in(1, 1, 0, 0, 0, 9'd7, 16'h0000, 16'h5555); tick();
    set_in(0, 1, 1, 0, 0, 9'd7, 16'h0000, 16'h1234); expect_rd("reset_mid", 16'h0000); tick();
    set_in(1, 0, 1, 0, 0, 9'd7, 16'h0000, 16'h0000); expect_rd("reset_nowrite", 16'h5555); tick();
    // Store / load / hold
    set_in(1, 1, 0, 0, 0, 9'd1, 16'h0000, 16'hAAAA); tick();
    set_in(1, 0, 0, 0, 0, 9'd1, 16'h0000, 16'h0000); tick();
    set_in(1, 0, 1, 0, 0, 9'd1, 16'h0000, 16'h0000); expect_rd("load_1", 16'hAAAA); tick();
    set_in(1, 0, 0, 0, 0, 9'd0, 16'h0000, 16'h0000); expect_rd("hold_1", 16'hAAAA); tick();
    set_in(1, 0, 0, 0, 0, 9'd2, 16'h0002, 16'h0000); expect_rd("hold_2", 16'hAAAA); tick();
    // Push / pop / alias
    set_in(1, 0, 0, 1, 0, 9'd0, 16'h0002, 16'hF0F0); tick();
    set_in(1, 0, 0, 0, 1, 9'd0, 16'h0002, 16'h0000); expect_rd("pop_2", 16'hF0F0); tick();
    set_in(1, 0, 0, 0, 1, 9'd0, 16'h0202, 16'h0000); expect_rd("pop_alias", 16'hF0F0); tick();
    // Independent ports: push at sp=10 while loading address 1
    set_in(1, 0, 1, 1, 0, 9'd1, 16'h000A, 16'h0A0A); expect_rd("load_while_push", 16'hAAAA); tick();
    set_in(1, 0, 0, 0, 1, 9'd0, 16'h000A, 16'h0000); expect_rd("pop_10", 16'h0A0A); tick();
    // Priority
    set_in(1, 1, 0, 0, 0, 9'd6, 16'h0000, 16'h6666); tick();
    set_in(1, 1, 0, 1, 0, 9'd5, 16'h0006, 16'h1111); tick();
    set_in(1, 0, 1, 0, 1, 9'd5, 16'h0006, 16'h0000); expect_rd("load_over_pop", 16'h1111); tick();
    set_in(1, 0, 0, 0, 1, 9'd0, 16'h0006, 16'h0000); expect_rd("push_ignored", 16'h6666); tick();
    // Read-first
    set_in(1, 1, 0, 0, 0, 9'd3, 16'h0000, 16'h0001); tick();
    set_in(1, 1, 1, 0, 0, 9'd3, 16'h0000, 16'h0002); expect_rd("read_first", 16'h0001); tick();
    set_in(1, 0, 1, 0, 0, 9'd3, 16'h0000, 16'h0000); expect_rd("after_write", 16'h0002); tick();
    // Address boundaries
    set_in(1, 1, 0, 0, 0, 9'd511, 16'h0000, 16'hBEEF); tick();
    set_in(1, 1, 0, 0, 0, 9'd0, 16'h0000, 16'hCAFE); tick();
    set_in(1, 0, 1, 0, 0, 9'd511, 16'h0000, 16'h0000); expect_rd("load_511", 16'hBEEF); tick();
    set_in(1, 0, 1, 0, 0, 9'd0, 16'h0000, 16'h0000); expect_rd("load_0", 16'hCAFE); tick();
    set_in(1, 0, 0, 0, 0, 9'd0, 16'h0000, 16'h0000);

    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: pending=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
